control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: program counter value after reset.
REQ-002 Parameter WD_CYCLES, default 255: watchdog limit in cycles; used only when CU_WATCHDOG_EN is defined.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 imem_req  output  1  instruction-word fetch request.
REQ-006 imem_addr  output  16  fetch address, equal to pc.
REQ-007 imem_ack  input  1  fetch data valid this cycle.
REQ-008 imem_data  input  16  fetched word.
REQ-009 alu_done  input  1  ALU completion pulse.
REQ-010 reg_done  input  1  register-file write completion pulse.
REQ-011 opcode  output  5  ALU opcode.
REQ-012 read_write  output  2  register-file command: 00 none, 01 read, 10 write port 0, 11 write ports 0 and 1.
REQ-013 control  output  3  data_in_0 source select: 000 ALU, 001 I/O, 011 immediate.
REQ-014 imm_val  output  16  immediate operand.
REQ-015 read_addr_0, read_addr_1, write_addr_0, write_addr_1  output  3 each  register addresses.
REQ-016 pc  output  16  current program counter.
REQ-017 halted  output  1  high in HALT; err  output  1  high in ERR.

Function
REQ-018 Instruction word fields: [15:11] opcode, [10:8] write_addr_0, [7:5] read_addr_0, [4:2] read_addr_1, [1:0] mode (00 ALU, 01 LOADI, 10 IN, 11 HALT).
REQ-019 write_addr_1 SHALL equal write_addr_0+1 modulo 8 (3-bit wrap; 7 wraps to 0).
REQ-020 States: FETCH, IMM, EXEC, WB, HALT, ERR; all outputs registered.
REQ-021 FETCH: imem_req=1, imem_addr=pc; on imem_ack latch word into IR, pc+=1 (16-bit wrap, FFFF->0000); next state by mode: 00->EXEC, 01->IMM, 10->WB, 11->HALT.
REQ-022 IMM: imem_req=1; on imem_ack latch imem_data into imm_val, pc+=1, ->WB.
REQ-023 EXEC: read_write=01, control=000; wait for alu_done, then ->WB; alu_done in the entry cycle counts.
REQ-024 WB: read_write = 11 for mode 00, 10 for modes 01 and 10; control = 000/011/001 for modes 00/01/10; on reg_done ->FETCH.
REQ-025 read_write SHALL be 00 in FETCH, IMM, HALT and ERR; imem_req SHALL be 0 outside FETCH and IMM.
REQ-026 alu_done outside EXEC and reg_done outside WB SHALL be ignored.
REQ-027 HALT and ERR are sticky; exit only by reset.
REQ-028 Without imem_ack the unit SHALL wait indefinitely in FETCH or IMM, holding imem_addr.

Reset
REQ-029 On a clk edge with rst=0: state=FETCH, pc=RESET_PC, IR=0, imm_val=0, opcode=0, read_write=00, control=000, all addresses 0, halted=0, err=0, watchdog counter=0.
REQ-030 Reset mid-instruction SHALL abandon it; no pending done pulse is honoured afterwards.

Configuration
REQ-031 Macro CU_WATCHDOG_EN defined: a counter runs in EXEC and WB, clears on state entry; on reaching WD_CYCLES without the done pulse ->ERR, err=1.
REQ-032 CU_WATCHDOG_EN undefined: no counter, EXEC/WB wait indefinitely, err tied 0, ERR unreachable.

Structure
REQ-033 Shared package cu_pkg SHALL hold the state enum, mode encodings, read_write encodings, control encodings and instruction field positions.
REQ-034 Sub-module cu_decode (combinational IR -> field/mode decode) SHALL be instantiated once; the FSM stays in control_unit.

Verification
REQ-035 Reset, word 16'h0A24 (op 1, wa0 2, ra0 1, ra1 1, ALU), alu_done after 3 cycles, then reg_done -> opcode=1, read_write 01 then 11, write_addr_1=3, pc=1.
REQ-036 LOADI 16'h0701 then 16'hBEEF -> imm_val=16'hBEEF, control=011, read_write=10, write_addr_0=7, write_addr_1=0, pc=2.
REQ-037 HALT word 16'h0003 -> halted=1 and stays 1; later imem_ack/alu_done/reg_done cause no change.
REQ-038 RESET_PC=16'hFFFF, ALU instruction fetched -> pc wraps to 16'h0000.
REQ-039 With CU_WATCHDOG_EN, WD_CYCLES=10, no alu_done -> err=1 after 10 EXEC cycles; without the macro, still in EXEC after 1000 cycles.
REQ-040 rst=0 while in WB, with reg_done on the following cycle -> state FETCH, pc=RESET_PC, read_write=00.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared types and encodings for the control unit: FSM states, instruction modes,
// register-file commands, data-source selects and instruction field positions.
package cu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_IMM   = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_HALT  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        MODE_ALU   = 2'b00,
        MODE_LOADI = 2'b01,
        MODE_IN    = 2'b10,
        MODE_HALT  = 2'b11
    } mode_e;

    localparam logic [1:0] RW_NONE = 2'b00;
    localparam logic [1:0] RW_READ = 2'b01;
    localparam logic [1:0] RW_WR0  = 2'b10;
    localparam logic [1:0] RW_WR01 = 2'b11;

    localparam logic [2:0] CTL_ALU = 3'b000;
    localparam logic [2:0] CTL_IO  = 3'b001;
    localparam logic [2:0] CTL_IMM = 3'b011;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 11;
    localparam int WA0_MSB    = 10;
    localparam int WA0_LSB    = 8;
    localparam int RA0_MSB    = 7;
    localparam int RA0_LSB    = 5;
    localparam int RA1_MSB    = 4;
    localparam int RA1_LSB    = 2;
    localparam int MODE_MSB   = 1;
    localparam int MODE_LSB   = 0;

    typedef struct packed {
        logic [4:0] opcode;
        logic [2:0] wa0;
        logic [2:0] wa1;
        logic [2:0] ra0;
        logic [2:0] ra1;
        mode_e      mode;
    } fields_t;

endpackage

// File: rtl/cu_decode.sv
// Purely combinational split of an instruction word into its fields; the second
// write port always targets the register after write_addr_0, wrapping 7 -> 0.
module cu_decode
    import cu_pkg::*;
(
    input  logic [15:0] ir_i,
    output fields_t     fields_o
);

    always_comb begin
        fields_o.opcode = ir_i[OPCODE_MSB:OPCODE_LSB];
        fields_o.wa0    = ir_i[WA0_MSB:WA0_LSB];
        fields_o.wa1    = ir_i[WA0_MSB:WA0_LSB] + 3'd1;
        fields_o.ra0    = ir_i[RA0_MSB:RA0_LSB];
        fields_o.ra1    = ir_i[RA1_MSB:RA1_LSB];
        fields_o.mode   = mode_e'(ir_i[MODE_MSB:MODE_LSB]);
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer (FETCH/IMM/EXEC/WB/HALT/ERR) with registered outputs.
// Define CU_WATCHDOG_EN to add a WD_CYCLES timeout on EXEC/WB that drops into ERR.
module control_unit
    import cu_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          WD_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    input  logic        alu_done,
    input  logic        reg_done,
    output logic [4:0]  opcode,
    output logic [1:0]  read_write,
    output logic [2:0]  control,
    output logic [15:0] imm_val,
    output logic [2:0]  read_addr_0,
    output logic [2:0]  read_addr_1,
    output logic [2:0]  write_addr_0,
    output logic [2:0]  write_addr_1,
    output logic [15:0] pc,
    output logic        halted,
    output logic        err
);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] imm_q, imm_d;
    logic [4:0]  op_q, op_d;
    logic [2:0]  wa0_q, wa0_d, wa1_q, wa1_d, ra0_q, ra0_d, ra1_q, ra1_d;
    logic        req_q, req_d;
    logic [1:0]  rw_q, rw_d;
    logic [2:0]  ctl_q, ctl_d;
    logic        halted_q, halted_d;
    logic        wd_expired;
    fields_t     fld;

    // Decoding the next IR lets the FSM branch on the mode of a word arriving this cycle.
    assign ir_d = (state_q == ST_FETCH && imem_ack) ? imem_data : ir_q;

    cu_decode u_decode (
        .ir_i     (ir_d),
        .fields_o (fld)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        imm_d   = imm_q;
        op_d    = op_q;
        wa0_d   = wa0_q;
        wa1_d   = wa1_q;
        ra0_d   = ra0_q;
        ra1_d   = ra1_q;
        unique case (state_q)
            ST_FETCH: if (imem_ack) begin
                pc_d  = pc_q + 16'd1;
                op_d  = fld.opcode;
                wa0_d = fld.wa0;
                wa1_d = fld.wa1;
                ra0_d = fld.ra0;
                ra1_d = fld.ra1;
                unique case (fld.mode)
                    MODE_ALU:   state_d = ST_EXEC;
                    MODE_LOADI: state_d = ST_IMM;
                    MODE_IN:    state_d = ST_WB;
                    MODE_HALT:  state_d = ST_HALT;
                endcase
            end
            ST_IMM: if (imem_ack) begin
                imm_d   = imem_data;
                pc_d    = pc_q + 16'd1;
                state_d = ST_WB;
            end
            ST_EXEC: begin
                if (alu_done)        state_d = ST_WB;
                else if (wd_expired) state_d = ST_ERR;
            end
            ST_WB: begin
                if (reg_done)        state_d = ST_FETCH;
                else if (wd_expired) state_d = ST_ERR;
            end
            default: state_d = state_q;
        endcase

        // Outputs are computed from the upcoming state so they register in step with it.
        req_d    = (state_d == ST_FETCH) || (state_d == ST_IMM);
        halted_d = (state_d == ST_HALT);
        rw_d     = RW_NONE;
        ctl_d    = CTL_ALU;
        if (state_d == ST_EXEC) begin
            rw_d = RW_READ;
        end else if (state_d == ST_WB) begin
            unique case (fld.mode)
                MODE_ALU:   begin rw_d = RW_WR01; ctl_d = CTL_ALU; end
                MODE_LOADI: begin rw_d = RW_WR0;  ctl_d = CTL_IMM; end
                MODE_IN:    begin rw_d = RW_WR0;  ctl_d = CTL_IO;  end
                default:    begin rw_d = RW_NONE; ctl_d = CTL_ALU; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            imm_q    <= '0;
            op_q     <= '0;
            wa0_q    <= '0;
            wa1_q    <= '0;
            ra0_q    <= '0;
            ra1_q    <= '0;
            req_q    <= 1'b1;
            rw_q     <= RW_NONE;
            ctl_q    <= CTL_ALU;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            imm_q    <= imm_d;
            op_q     <= op_d;
            wa0_q    <= wa0_d;
            wa1_q    <= wa1_d;
            ra0_q    <= ra0_d;
            ra1_q    <= ra1_d;
            req_q    <= req_d;
            rw_q     <= rw_d;
            ctl_q    <= ctl_d;
            halted_q <= halted_d;
        end
    end

`ifdef CU_WATCHDOG_EN
    localparam int WdW = $clog2(WD_CYCLES + 1);

    logic [WdW-1:0] wd_q;
    logic           err_q;

    assign wd_expired = (wd_q == WdW'(WD_CYCLES - 1));

    // Counts waiting cycles in EXEC/WB and restarts from zero whenever the state changes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= (state_d == ST_ERR);
            if (state_d != state_q)
                wd_q <= '0;
            else if (state_q == ST_EXEC || state_q == ST_WB)
                wd_q <= wd_q + 1'b1;
        end
    end

    assign err = err_q;
`else
    assign wd_expired = 1'b0;
    assign err        = 1'b0;
`endif

    assign imem_req     = req_q;
    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign opcode       = op_q;
    assign read_write   = rw_q;
    assign control      = ctl_q;
    assign imm_val      = imm_q;
    assign read_addr_0  = ra0_q;
    assign read_addr_1  = ra1_q;
    assign write_addr_0 = wa0_q;
    assign write_addr_1 = wa1_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus a randomized instruction
// stream checked cycle by cycle against a transaction-level model of the sequencer.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic        alu_done = 1'b0;
    logic        reg_done = 1'b0;

    logic        imem_req, halted, err;
    logic [15:0] imem_addr, imm_val, pc;
    logic [4:0]  opcode;
    logic [1:0]  read_write;
    logic [2:0]  control, read_addr_0, read_addr_1, write_addr_0, write_addr_1;

    logic        imem_req_w, halted_w, err_w;
    logic [15:0] imem_addr_w, imm_val_w, pc_w;
    logic [4:0]  opcode_w;
    logic [1:0]  read_write_w;
    logic [2:0]  control_w, read_addr_0_w, read_addr_1_w, write_addr_0_w, write_addr_1_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    control_unit #(.RESET_PC(16'h0000), .WD_CYCLES(10)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .alu_done(alu_done), .reg_done(reg_done),
        .opcode(opcode), .read_write(read_write), .control(control), .imm_val(imm_val),
        .read_addr_0(read_addr_0), .read_addr_1(read_addr_1),
        .write_addr_0(write_addr_0), .write_addr_1(write_addr_1),
        .pc(pc), .halted(halted), .err(err)
    );

    control_unit #(.RESET_PC(16'hFFFF), .WD_CYCLES(10)) dut_w (
        .clk(clk), .rst(rst), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_ack(imem_ack), .imem_data(imem_data), .alu_done(alu_done), .reg_done(reg_done),
        .opcode(opcode_w), .read_write(read_write_w), .control(control_w), .imm_val(imm_val_w),
        .read_addr_0(read_addr_0_w), .read_addr_1(read_addr_1_w),
        .write_addr_0(write_addr_0_w), .write_addr_1(write_addr_1_w),
        .pc(pc_w), .halted(halted_w), .err(err_w)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b0; alu_done = 1'b0; reg_done = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b1; imem_data = 16'hFFFF; alu_done = 1'b1; reg_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; imem_ack = 1'b0; alu_done = 1'b0; reg_done = 1'b0;
        n_checks++;
        if (pc !== 16'h0000 || imem_addr !== 16'h0000 || imem_req !== 1'b1) begin
            n_fail++; $display("[TB] FAIL reset_pc: pc=%h addr=%h req=%b, expected 0000 0000 1", pc, imem_addr, imem_req);
        end
        n_checks++;
        if (read_write !== 2'b00 || control !== 3'b000 || opcode !== 5'd0 || imm_val !== 16'h0000) begin
            n_fail++; $display("[TB] FAIL reset_outs: rw=%b ctl=%b op=%h imm=%h, expected all zero", read_write, control, opcode, imm_val);
        end
        n_checks++;
        if ({read_addr_0, read_addr_1, write_addr_0, write_addr_1} !== 12'h000 || halted !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_addrs: ra0=%0d ra1=%0d wa0=%0d wa1=%0d halted=%b err=%b, expected all zero",
                               read_addr_0, read_addr_1, write_addr_0, write_addr_1, halted, err);
        end
        n_checks++;
        if (pc_w !== 16'hFFFF) begin
            n_fail++; $display("[TB] FAIL reset_pc_param: pc=%h, expected ffff", pc_w);
        end
    endtask

    task automatic test_alu();
        do_reset();
        imem_data = 16'h0A24; imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0; imem_data = 16'($urandom);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (read_write !== 2'b01 || opcode !== 5'd1 || write_addr_1 !== 3'd3 || pc !== 16'h0001 || imem_req !== 1'b0) begin
                n_fail++; $display("[TB] FAIL alu_exec: rw=%b op=%0d wa1=%0d pc=%h req=%b, expected 01 1 3 0001 0",
                                   read_write, opcode, write_addr_1, pc, imem_req);
            end
            @(negedge clk);
        end
        alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
        n_checks++;
        if (read_write !== 2'b11 || control !== 3'b000 || write_addr_0 !== 3'd2 || read_addr_0 !== 3'd1 || read_addr_1 !== 3'd1) begin
            n_fail++; $display("[TB] FAIL alu_wb: rw=%b ctl=%b wa0=%0d ra0=%0d ra1=%0d, expected 11 000 2 1 1",
                               read_write, control, write_addr_0, read_addr_0, read_addr_1);
        end
        reg_done = 1'b1;
        @(negedge clk);
        reg_done = 1'b0;
        n_checks++;
        if (read_write !== 2'b00 || imem_req !== 1'b1 || imem_addr !== 16'h0001) begin
            n_fail++; $display("[TB] FAIL alu_refetch: rw=%b req=%b addr=%h, expected 00 1 0001", read_write, imem_req, imem_addr);
        end
    endtask

    task automatic test_loadi();
        do_reset();
        imem_data = 16'h0701; imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0001 || read_write !== 2'b00) begin
            n_fail++; $display("[TB] FAIL loadi_imm: req=%b addr=%h rw=%b, expected 1 0001 00", imem_req, imem_addr, read_write);
        end
        imem_data = 16'hBEEF; imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0; imem_data = 16'h0000;
        n_checks++;
        if (imm_val !== 16'hBEEF || control !== 3'b011 || read_write !== 2'b10) begin
            n_fail++; $display("[TB] FAIL loadi_wb: imm=%h ctl=%b rw=%b, expected beef 011 10", imm_val, control, read_write);
        end
        n_checks++;
        if (write_addr_0 !== 3'd7 || write_addr_1 !== 3'd0 || pc !== 16'h0002 || imem_req !== 1'b0) begin
            n_fail++; $display("[TB] FAIL loadi_addr: wa0=%0d wa1=%0d pc=%h req=%b, expected 7 0 0002 0",
                               write_addr_0, write_addr_1, pc, imem_req);
        end
    endtask

    task automatic test_halt();
        do_reset();
        imem_data = 16'h0003; imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        n_checks++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || read_write !== 2'b00 || pc !== 16'h0001) begin
            n_fail++; $display("[TB] FAIL halt_enter: halted=%b req=%b rw=%b pc=%h, expected 1 0 00 0001", halted, imem_req, read_write, pc);
        end
        for (int i = 0; i < 20; i++) begin
            imem_ack = 1'($urandom); imem_data = 16'($urandom);
            alu_done = 1'($urandom); reg_done = 1'($urandom);
            @(negedge clk);
            n_checks++;
            if (halted !== 1'b1 || pc !== 16'h0001 || read_write !== 2'b00 || imem_req !== 1'b0) begin
                n_fail++; $display("[TB] FAIL halt_sticky: halted=%b pc=%h rw=%b req=%b, expected 1 0001 00 0", halted, pc, read_write, imem_req);
            end
        end
        imem_ack = 1'b0; alu_done = 1'b0; reg_done = 1'b0;
        do_reset();
        n_checks++;
        if (halted !== 1'b0 || imem_req !== 1'b1) begin
            n_fail++; $display("[TB] FAIL halt_reset: halted=%b req=%b, expected 0 1", halted, imem_req);
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        imem_data = 16'h0A24; imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        n_checks++;
        if (pc_w !== 16'h0000 || imem_addr_w !== 16'h0000 || read_write_w !== 2'b01) begin
            n_fail++; $display("[TB] FAIL pc_wrap: pc=%h addr=%h rw=%b, expected 0000 0000 01", pc_w, imem_addr_w, read_write_w);
        end
    endtask

    task automatic test_exec_wait();
        do_reset();
        imem_data = 16'h0A24; imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
`ifdef CU_WATCHDOG_EN
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (err !== 1'b0 || read_write !== 2'b01) begin
                n_fail++; $display("[TB] FAIL wd_wait: cycle %0d err=%b rw=%b, expected 0 01", i, err, read_write);
            end
            reg_done = 1'($urandom);
            @(negedge clk);
        end
        reg_done = 1'b0;
        n_checks++;
        if (err !== 1'b1 || read_write !== 2'b00 || imem_req !== 1'b0) begin
            n_fail++; $display("[TB] FAIL wd_err: err=%b rw=%b req=%b, expected 1 00 0", err, read_write, imem_req);
        end
        alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
        n_checks++;
        if (err !== 1'b1 || read_write !== 2'b00) begin
            n_fail++; $display("[TB] FAIL wd_err_sticky: err=%b rw=%b, expected 1 00", err, read_write);
        end
`else
        for (int i = 0; i < 1000; i++) begin
            reg_done = 1'($urandom);
            @(negedge clk);
        end
        reg_done = 1'b0;
        n_checks++;
        if (read_write !== 2'b01 || err !== 1'b0 || imem_req !== 1'b0 || pc !== 16'h0001) begin
            n_fail++; $display("[TB] FAIL exec_wait: rw=%b err=%b req=%b pc=%h, expected 01 0 0 0001", read_write, err, imem_req, pc);
        end
        alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
        n_checks++;
        if (read_write !== 2'b11) begin
            n_fail++; $display("[TB] FAIL exec_release: rw=%b, expected 11", read_write);
        end
`endif
    endtask

    task automatic test_reset_in_wb();
        do_reset();
        imem_data = 16'h0312; imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        n_checks++;
        if (read_write !== 2'b10 || control !== 3'b001 || write_addr_0 !== 3'd3 || write_addr_1 !== 3'd4 || read_addr_1 !== 3'd4) begin
            n_fail++; $display("[TB] FAIL in_wb: rw=%b ctl=%b wa0=%0d wa1=%0d ra1=%0d, expected 10 001 3 4 4",
                               read_write, control, write_addr_0, write_addr_1, read_addr_1);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; reg_done = 1'b1;
        @(negedge clk);
        reg_done = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || pc !== 16'h0000 || read_write !== 2'b00 || control !== 3'b000) begin
            n_fail++; $display("[TB] FAIL wb_reset: req=%b pc=%h rw=%b ctl=%b, expected 1 0000 00 000", imem_req, pc, read_write, control);
        end
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || read_write !== 2'b00) begin
            n_fail++; $display("[TB] FAIL wb_reset_hold: req=%b addr=%h rw=%b, expected 1 0000 00", imem_req, imem_addr, read_write);
        end
    endtask

    task automatic test_random();
        logic [15:0] word, imm;
        logic [1:0]  mode, e_rw;
        logic [2:0]  e_ctl, e_wa1;
        int          exp_pc, dF, dI, dE, dW;
        do_reset();
        exp_pc = 0;
        for (int n = 0; n < 40; n++) begin
            word       = 16'($urandom);
            mode       = 2'($urandom_range(0, 2));
            word[1:0]  = mode;
            imm        = 16'($urandom);
            e_wa1      = 3'((int'(word[10:8]) + 1) % 8);
            e_rw       = (mode == 2'b00) ? 2'b11 : 2'b10;
            e_ctl      = (mode == 2'b00) ? 3'b000 : (mode == 2'b01) ? 3'b011 : 3'b001;
            dF = $urandom_range(0, 3); dI = $urandom_range(0, 3);
            dE = $urandom_range(0, 4); dW = $urandom_range(0, 4);

            for (int i = 0; i <= dF; i++) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== 16'(exp_pc) || read_write !== 2'b00) begin
                    n_fail++; $display("[TB] FAIL rand_fetch: req=%b addr=%h rw=%b, expected 1 %h 00", imem_req, imem_addr, read_write, 16'(exp_pc));
                end
                imem_ack  = (i == dF);
                imem_data = (i == dF) ? word : 16'($urandom);
                alu_done  = 1'($urandom); reg_done = 1'($urandom);
                @(negedge clk);
            end
            imem_ack = 1'b0;
            exp_pc = (exp_pc + 1) % 65536;

            if (mode == 2'b01) begin
                for (int i = 0; i <= dI; i++) begin
                    n_checks++;
                    if (imem_req !== 1'b1 || imem_addr !== 16'(exp_pc) || read_write !== 2'b00 || opcode !== word[15:11]) begin
                        n_fail++; $display("[TB] FAIL rand_imm: req=%b addr=%h rw=%b op=%h, expected 1 %h 00 %h",
                                           imem_req, imem_addr, read_write, opcode, 16'(exp_pc), word[15:11]);
                    end
                    imem_ack  = (i == dI);
                    imem_data = (i == dI) ? imm : 16'($urandom);
                    alu_done  = 1'($urandom); reg_done = 1'($urandom);
                    @(negedge clk);
                end
                imem_ack = 1'b0;
                exp_pc = (exp_pc + 1) % 65536;
            end

            if (mode == 2'b00) begin
                for (int i = 0; i <= dE; i++) begin
                    n_checks++;
                    if (imem_req !== 1'b0 || read_write !== 2'b01 || control !== 3'b000 || opcode !== word[15:11] ||
                        read_addr_0 !== word[7:5] || read_addr_1 !== word[4:2]) begin
                        n_fail++; $display("[TB] FAIL rand_exec: req=%b rw=%b ctl=%b op=%h ra0=%0d ra1=%0d, expected 0 01 000 %h %0d %0d",
                                           imem_req, read_write, control, opcode, read_addr_0, read_addr_1, word[15:11], word[7:5], word[4:2]);
                    end
                    alu_done = (i == dE); reg_done = 1'($urandom);
                    @(negedge clk);
                end
                alu_done = 1'b0;
            end

            for (int i = 0; i <= dW; i++) begin
                n_checks++;
                if (imem_req !== 1'b0 || read_write !== e_rw || control !== e_ctl || pc !== 16'(exp_pc) ||
                    write_addr_0 !== word[10:8] || write_addr_1 !== e_wa1 || (mode == 2'b01 && imm_val !== imm)) begin
                    n_fail++; $display("[TB] FAIL rand_wb: req=%b rw=%b ctl=%b pc=%h wa0=%0d wa1=%0d imm=%h, expected 0 %b %b %h %0d %0d %h",
                                       imem_req, read_write, control, pc, write_addr_0, write_addr_1, imm_val,
                                       e_rw, e_ctl, 16'(exp_pc), word[10:8], e_wa1, imm);
                end
                reg_done = (i == dW); alu_done = 1'($urandom);
                @(negedge clk);
            end
            reg_done = 1'b0; alu_done = 1'b0;
        end
    endtask

    initial begin
        $display("[TB] control_unit bench start");
        test_reset();
        test_alu();
        test_loadi();
        test_halt();
        test_pc_wrap();
        test_exec_wait();
        test_reset_in_wb();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
